// File: rtl/dz_uart_rx.sv
// Oversampling UART receiver: 5..8 data bits, optional parity, break handling.
// Define DZ_UART_RX_SYNC_EN to pass rxd through a two-flop synchronizer first.
module dz_uart_rx #(
  parameter int unsigned SAMPLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       clken,
  input  logic       rxen,
  input  logic [1:0] length,
  input  logic       paren,
  input  logic       parodd,
  input  logic       rxd,
  input  logic       rxclr,
  output logic [7:0] rxdata,
  output logic       rxfull,
  output logic       rxpare,
  output logic       rxfrme
);

  localparam int unsigned CW = $clog2(SAMPLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(SAMPLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(SAMPLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          par_acc;
  logic          pare_q;
  logic [1:0]    len_q;
  logic          paren_q;
  logic          parodd_q;
  logic          line;

`ifdef DZ_UART_RX_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     sync <= '1;
    else if (clr) sync <= '1;
    else          sync <= {sync[0], rxd};
  end

  assign line = sync[1];
`else
  assign line = rxd;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      pare_q   <= 1'b0;
      len_q    <= '0;
      paren_q  <= 1'b0;
      parodd_q <= 1'b0;
      rxdata   <= '0;
      rxfull   <= 1'b0;
      rxpare   <= 1'b0;
      rxfrme   <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      pare_q   <= 1'b0;
      len_q    <= '0;
      paren_q  <= 1'b0;
      parodd_q <= 1'b0;
      rxdata   <= '0;
      rxfull   <= 1'b0;
      rxpare   <= 1'b0;
      rxfrme   <= 1'b0;
    end else begin
      // rxclr is applied first so a completion on the same edge overrides it
      if (rxclr) rxfull <= 1'b0;
      if (!rxen) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (clken) begin
        case (state)
          IDLE: begin
            if (!line) begin
              state    <= START;
              cnt      <= '0;
              bitn     <= '0;
              shreg    <= '0;
              par_acc  <= 1'b0;
              pare_q   <= 1'b0;
              len_q    <= length;
              paren_q  <= paren;
              parodd_q <= parodd;
            end
          end
          START: begin
            if (cnt == HALF_LAST) begin
              cnt   <= '0;
              state <= line ? IDLE : DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == BIT_LAST) begin
              cnt         <= '0;
              shreg[bitn] <= line;
              par_acc     <= par_acc ^ line;
              if (bitn == ({1'b0, len_q} + 3'd4)) state <= paren_q ? PARITY : STOP;
              else                                 bitn  <= bitn + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            if (cnt == BIT_LAST) begin
              cnt    <= '0;
              pare_q <= par_acc ^ line ^ parodd_q;
              state  <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == BIT_LAST) begin
              cnt    <= '0;
              rxdata <= shreg;
              rxpare <= paren_q & pare_q;
              rxfrme <= ~line;
              rxfull <= 1'b1;
              state  <= line ? IDLE : BREAK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BREAK: begin
            if (line) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dz_uart_rx.md
DZ_UART_RX -- requirements
Module: dz_uart_rx

Interface
REQ-001 SHALL have parameter SAMPLES, default 16: clken ticks per bit; power of two, 8..32.
REQ-002 SHALL have port clk  input  1  clock; all flops on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous clear, same effect as reset.
REQ-005 SHALL have port clken  input  1  oversample tick at SAMPLES x baud rate.
REQ-006 SHALL have port rxen  input  1  LPR receiver enable.
REQ-007 SHALL have port length  input  2  data bits = length+5 (5..8).
REQ-008 SHALL have port paren  input  1  parity enable.
REQ-009 SHALL have port parodd  input  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have port rxd  input  1  serial line, idle high.
REQ-011 SHALL have port rxclr  input  1  clear rxfull; one clk pulse from RBUF scanner.
REQ-012 SHALL have port rxdata  output  8  received character, right-justified, unused high bits 0.
REQ-013 SHALL have port rxfull  output  1  character available.
REQ-014 SHALL have port rxpare  output  1  parity error for the held character.
REQ-015 SHALL have port rxfrme  output  1  framing error for the held character.

Function
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK; state and sample-counter updates occur only on clk edges with clken=1.
REQ-017 IDLE: SHALL go to START on the first tick with rxd=0 and rxen=1; clear the sample counter; latch length, paren and parodd for the whole character.
REQ-018 START: SHALL resample rxd at tick SAMPLES/2-1; if rxd=1, return to IDLE with no output change (false start); otherwise go to DATA.
REQ-019 DATA: SHALL sample each bit every SAMPLES ticks after the mid-start sample, LSB first; after length+5 bits go to PARITY if paren=1, else STOP.
REQ-020 PARITY: SHALL sample one bit; the error is set if (XOR of data bits XOR parity bit XOR parodd) = 1.
REQ-021 STOP: SHALL sample one bit; frame error = (rxd==0).
REQ-022 On the stop-sample clk edge, SHALL load rxdata, rxpare (0 if paren=0) and rxfrme, and set rxfull.
REQ-023 After the stop sample, SHALL go to IDLE if the stop bit = 1, else to BREAK.
REQ-024 BREAK: SHALL remain until a tick with rxd=1, then go to IDLE; this delivers exactly one character per break.
REQ-025 rxclr=1 SHALL clear rxfull on the next clk edge; rxdata, rxpare and rxfrme SHALL hold.
REQ-026 If rxclr and character completion coincide, completion SHALL win: rxfull=1 and the new data is loaded.
REQ-027 Completion while rxfull=1 SHALL overwrite rxdata, rxpare and rxfrme; rxfull SHALL stay 1.
REQ-028 rxen=0 SHALL force IDLE at the next clk edge, abort any partial character, and leave rxfull and the held data unchanged.
REQ-029 Changes to length, paren or parodd mid-character SHALL take effect only at the next start bit.

Reset
REQ-030 rst low SHALL asynchronously force state=IDLE, counter=0, rxdata=0x00, rxfull=0, rxpare=0, rxfrme=0.
REQ-031 clr=1 SHALL produce identical values on the next clk edge; clr SHALL take priority over all other inputs.
REQ-032 Reset or clr asserted mid-character SHALL discard the partial character.

Configuration
REQ-033 With DZ_UART_RX_SYNC_EN defined, rxd SHALL pass through a two-flop synchronizer (reset value 1) before use; all latencies grow by 2 clk.
REQ-034 Without DZ_UART_RX_SYNC_EN, rxd SHALL be used directly with no added latency.

Verification
REQ-035 8N1, SAMPLES=16, send 0xA5 -> rxdata=0xA5, rxfull=1, rxpare=0, rxfrme=0 at tick 152 after the start edge (±2 clk with the sync macro).
REQ-036 7E1 (length=2, paren=1, parodd=0), send 0x41 with parity bit 1 -> rxdata=0x41, rxpare=1.
REQ-037 5N1, send 0x1F -> rxdata=0x1F with bits 7:5=0; then rxclr pulse -> rxfull=0, rxdata still 0x1F.
REQ-038 rxd low for 4 ticks only -> no state beyond START, rxfull stays 0.
REQ-039 rxd held low for 3 character times -> exactly one character 0x00 with rxfrme=1, then nothing more until rxd returns high.
REQ-040 rxclr coincident with completion -> rxfull=1 and new data present; rst low mid-DATA -> all outputs 0, next clean 0x55 received correctly.
